// File: rtl/counter_pkg.sv
// Shared types for the nested range counter.
package counter_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/range_step_dim.sv
// One loop dimension: end-of-range compare and next-value select.
module range_step_dim #(
  parameter int unsigned Bits = 8
) (
  input  logic [Bits-1:0] count,
  input  logic [Bits-1:0] start_val,
  input  logic [Bits-1:0] end_val,
  input  logic [Bits-1:0] step,
  output logic            at_end_c,
  output logic [Bits-1:0] next_c
);

  localparam int unsigned SumW = Bits + 1;

  logic [SumW-1:0] sum;
  logic            degenerate;

  // Sum is one bit wider so a step past the top of the range never aliases low.
  always_comb begin
    sum        = SumW'(count) + SumW'(step);
    degenerate = (end_val < start_val);
    at_end_c   = degenerate || (sum > SumW'(end_val));
    next_c     = at_end_c ? start_val : sum[Bits-1:0];
  end

endmodule

// File: rtl/nested_range_counter.sv
// Nested loop counter: Dims dimensions, dimension 0 innermost, with stop or wrap at the final point.
module nested_range_counter #(
  parameter int unsigned Bits = 8,
  parameter int unsigned Dims = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic                      en_i,
  input  logic                      wrap_i,
  input  logic [Dims-1:0][Bits-1:0] start_val_i,
  input  logic [Dims-1:0][Bits-1:0] end_val_i,
  input  logic [Dims-1:0][Bits-1:0] step_i,
  input  logic                      assert_on_i,
  output logic [Dims-1:0][Bits-1:0] count_o,
  output logic                      busy_o,
  output logic                      last_o,
  output logic                      done_o
);

  import counter_pkg::*;

  state_e                    state_q, state_d;
  logic [Dims-1:0][Bits-1:0] cfg_start_q;
  logic [Dims-1:0][Bits-1:0] cfg_end_q;
  logic [Dims-1:0][Bits-1:0] cfg_step_q;
  logic                      cfg_wrap_q;
  logic [Dims-1:0][Bits-1:0] count_q, count_d;
  logic                      done_q, done_d;
  logic                      load_cfg;

  logic [Dims-1:0][Bits-1:0] step_fix;
  logic [Dims-1:0][Bits-1:0] next_val;
  logic [Dims-1:0]           at_end;
  logic [Dims-1:0]           adv;
  logic                      all_end;

  // A zero step would never leave its start value, so it is stored as one.
  always_comb begin
    for (int d = 0; d < Dims; d++) begin
      step_fix[d] = (step_i[d] == '0) ? Bits'(1) : step_i[d];
    end
  end

  // Per-dimension compare and reload logic.
  for (genvar g = 0; g < Dims; g++) begin : g_dim
    range_step_dim #(
      .Bits(Bits)
    ) u_dim (
      .count    (count_q[g]),
      .start_val(cfg_start_q[g]),
      .end_val  (cfg_end_q[g]),
      .step     (cfg_step_q[g]),
      .at_end_c (at_end[g]),
      .next_c   (next_val[g])
    );
  end

  // Carry chain: a dimension advances only when every inner dimension is at its end.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int d = 0; d < Dims; d++) begin
      adv[d] = carry;
      carry  = carry & at_end[d];
    end
    all_end = carry;
  end

  // Next-state, next-count and done pulse; start_i overrides any advance.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
    load_cfg = 1'b0;
    if (start_i) begin
      load_cfg = 1'b1;
      count_d  = start_val_i;
      state_d  = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (en_i) begin
            if (all_end) begin
              done_d = 1'b1;
              if (cfg_wrap_q) begin
                count_d = cfg_start_q;
              end else begin
                state_d = HOLD;
              end
            end else begin
              for (int d = 0; d < Dims; d++) begin
                if (adv[d]) begin
                  count_d[d] = next_val[d];
                end
              end
            end
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, count and latched configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      count_q     <= '0;
      done_q      <= 1'b0;
      cfg_start_q <= '0;
      cfg_end_q   <= '0;
      cfg_step_q  <= '0;
      cfg_wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      if (load_cfg) begin
        cfg_start_q <= start_val_i;
        cfg_end_q   <= end_val_i;
        cfg_step_q  <= step_fix;
        cfg_wrap_q  <= wrap_i;
      end
    end
  end

  assign count_o = count_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q == RUN);
  assign last_o  = ((state_q == RUN) && all_end) || (state_q == HOLD);

  // A dimension whose end is below its start collapses to its start value; flag it at start.
  for (genvar g = 0; g < Dims; g++) begin : g_chk
    a_cfg_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (start_i && assert_on_i) |-> (end_val_i[g] >= start_val_i[g]))
      else $error("nested_range_counter: dimension %0d end below start", g);
  end

endmodule

// File: tb/tb_nested_range_counter.sv
// Self-checking bench for nested_range_counter (Bits=8, Dims=2).
module tb_nested_range_counter;

  localparam int unsigned Bits = 8;
  localparam int unsigned Dims = 2;

  typedef struct {
    string       tag;
    logic [15:0] cnt;
    logic        busy;
    logic        last;
    logic        done;
  } exp_t;

  logic                      clk_i;
  logic                      rst_ni;
  logic                      start_i;
  logic                      en_i;
  logic                      wrap_i;
  logic [Dims-1:0][Bits-1:0] start_val_i;
  logic [Dims-1:0][Bits-1:0] end_val_i;
  logic [Dims-1:0][Bits-1:0] step_i;
  logic                      assert_on_i;
  logic [Dims-1:0][Bits-1:0] count_o;
  logic                      busy_o;
  logic                      last_o;
  logic                      done_o;

  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  nested_range_counter #(
    .Bits(Bits),
    .Dims(Dims)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .en_i       (en_i),
    .wrap_i     (wrap_i),
    .start_val_i(start_val_i),
    .end_val_i  (end_val_i),
    .step_i     (step_i),
    .assert_on_i(assert_on_i),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .last_o     (last_o),
    .done_o     (done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check({e.tag, ".count"}, 32'(count_o), 32'(e.cnt));
    check({e.tag, ".busy"},  32'(busy_o),  32'(e.busy));
    check({e.tag, ".last"},  32'(last_o),  32'(e.last));
    check({e.tag, ".done"},  32'(done_o),  32'(e.done));
  endtask

  task automatic set_cfg(input logic [7:0] s0, input logic [7:0] e0, input logic [7:0] p0,
                         input logic [7:0] s1, input logic [7:0] e1, input logic [7:0] p1,
                         input logic w);
    start_val_i = {s1, s0};
    end_val_i   = {e1, e0};
    step_i      = {p1, p0};
    wrap_i      = w;
  endtask

  // Drive one cycle of stimulus, queue the expected result, then compare after the edge.
  task automatic drive(input logic st, input logic en, input string tag,
                       input logic [15:0] cnt, input logic b, input logic l, input logic d);
    exp_t e;
    exp_t got_e;
    @(negedge clk_i);
    start_i = st;
    en_i    = en;
    e.tag = tag; e.cnt = cnt; e.busy = b; e.last = l; e.done = d;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      got_e = sb_q.pop_front();
      check_outputs(got_e);
    end
  endtask

  initial begin
    exp_t z;
    n_checks    = 0;
    n_errors    = 0;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    en_i        = 1'b0;
    assert_on_i = 1'b1;
    set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

    // Reset values.
    #2;
    z.tag = "reset"; z.cnt = 16'h0000; z.busy = 1'b0; z.last = 1'b0; z.done = 1'b0;
    check_outputs(z);
    #10 rst_ni = 1'b1;
    drive(1'b0, 1'b1, "idle_en", 16'h0000, 1'b0, 1'b0, 1'b0);

    // Single dimension, stop mode: 0,3,6,9 then HOLD.
    set_cfg(8'd0, 8'd9, 8'd3, 8'd0, 8'd0, 8'd1, 1'b0);
    drive(1'b1, 1'b1, "a_start", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "a_3",     16'h0003, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "a_6",     16'h0006, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "a_9",     16'h0009, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, "a_done",  16'h0009, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, "a_hold",  16'h0009, 1'b0, 1'b1, 1'b0);

    // Two dimensions, wrap mode; live inputs scrambled after start.
    set_cfg(8'd0, 8'd2, 8'd1, 8'd0, 8'd1, 8'd1, 1'b1);
    drive(1'b1, 1'b0, "b_start", 16'h0000, 1'b1, 1'b0, 1'b0);
    set_cfg(8'h33, 8'h44, 8'h05, 8'h11, 8'h12, 8'h07, 1'b0);
    drive(1'b0, 1'b1, "b_01",   16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, "b_hold", 16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "b_02",   16'h0002, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "b_10",   16'h0100, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "b_11",   16'h0101, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "b_12",   16'h0102, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, "b_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, "b_01b",  16'h0001, 1'b1, 1'b0, 1'b0);

    // Toggling enable: advance only on en-high cycles.
    set_cfg(8'd0, 8'd2, 8'd1, 8'd0, 8'd1, 8'd1, 1'b1);
    drive(1'b1, 1'b0, "c_start", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, "c_e0a",   16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "c_e1a",   16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, "c_e0b",   16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "c_e1b",   16'h0002, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, "c_e0c",   16'h0002, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "c_e1c",   16'h0100, 1'b1, 1'b0, 1'b0);

    // Restart mid-run with en high: load new start, no advance.
    set_cfg(8'd1, 8'd20, 8'd2, 8'd0, 8'd0, 8'd1, 1'b0);
    drive(1'b1, 1'b0, "d_start",   16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "d_3",       16'h0003, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "d_5",       16'h0005, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "d_7",       16'h0007, 1'b1, 1'b0, 1'b0);
    set_cfg(8'd5, 8'd20, 8'd2, 8'd0, 8'd0, 8'd1, 1'b0);
    drive(1'b1, 1'b1, "d_restart", 16'h0005, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "d_after",   16'h0007, 1'b1, 1'b0, 1'b0);

    // Top of the counter range: no wrap through zero.
    set_cfg(8'hFA, 8'hFF, 8'd4, 8'd0, 8'd0, 8'd1, 1'b0);
    drive(1'b1, 1'b0, "e_start", 16'h00FA, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "e_fe",    16'h00FE, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, "e_done",  16'h00FE, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, "e_hold",  16'h00FE, 1'b0, 1'b1, 1'b0);

    // Zero step behaves as one (restart from HOLD).
    set_cfg(8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1, 1'b0);
    drive(1'b1, 1'b0, "s0_start", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "s0_1",     16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "s0_2",     16'h0002, 1'b1, 1'b1, 1'b0);

    // Inner dimension with end below start collapses to its start value.
    assert_on_i = 1'b0;
    set_cfg(8'd5, 8'd3, 8'd1, 8'd0, 8'd2, 8'd1, 1'b0);
    drive(1'b1, 1'b0, "g_start", 16'h0005, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "g_15",    16'h0105, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "g_25",    16'h0205, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, "g_done",  16'h0205, 1'b0, 1'b1, 1'b1);
    assert_on_i = 1'b1;

    // Asynchronous reset pulse mid-run.
    set_cfg(8'd0, 8'd2, 8'd1, 8'd0, 8'd1, 8'd1, 1'b1);
    drive(1'b1, 1'b0, "f_start", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "f_01",    16'h0001, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "f_02",    16'h0002, 1'b1, 1'b0, 1'b0);
    #1 rst_ni = 1'b0;
    #1;
    z.tag = "f_rst_low"; z.cnt = 16'h0000; z.busy = 1'b0; z.last = 1'b0; z.done = 1'b0;
    check_outputs(z);
    #1 rst_ni = 1'b1;
    start_i = 1'b0;
    en_i    = 1'b1;
    drive(1'b0, 1'b1, "f_idle",    16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, "f_restart", 16'h0000, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, "f_run",     16'h0001, 1'b1, 1'b0, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nested_range_counter.md
NESTED_RANGE_COUNTER -- requirements
Module: nested_range_counter

Interface
REQ-001 Parameter Bits, default 8, width of each dimension's counter.
REQ-002 Parameter Dims, default 2, number of nested dimensions; dimension 0 is innermost (fastest).
REQ-003 The block SHALL use exactly one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-004 clk_i  in  1  clock, all state on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  latch configuration, load start values, enter RUN.
REQ-007 en_i  in  1  advance one step when RUN.
REQ-008 wrap_i  in  1  mode, latched at start: 0 = stop at final point, 1 = restart from start values.
REQ-009 start_val_i  in  Dims x Bits  per-dimension start value.
REQ-010 end_val_i  in  Dims x Bits  per-dimension inclusive end value.
REQ-011 step_i  in  Dims x Bits  per-dimension increment.
REQ-012 assert_on_i  in  1  enables simulation checks.
REQ-013 count_o  out  Dims x Bits  current point of the loop nest.
REQ-014 busy_o  out  1  high in RUN.
REQ-015 last_o  out  1  high when count_o is the final point of the nest (combinational from state).
REQ-016 done_o  out  1  one-cycle pulse on the step that consumes the final point.

Function
REQ-017 States SHALL be IDLE, RUN, HOLD; reset enters IDLE.
REQ-018 start_i in any state SHALL latch start/end/step/wrap into internal registers, set count_o to start_val_i, and enter RUN next cycle; the latched values govern the run, not live inputs.
REQ-019 start_i SHALL take priority over en_i in the same cycle; no advance occurs.
REQ-020 A latched step of 0 SHALL be treated as 1.
REQ-021 at_end[d] SHALL be true when count[d] + step[d] > end[d], computed in Bits+1 bits (no overflow aliasing).
REQ-022 In RUN with en_i high, dimension d SHALL advance iff all dimensions below d are at_end; an advancing dimension that is at_end reloads its start value, otherwise adds step.
REQ-023 last_o SHALL equal AND of at_end over all dimensions while in RUN; 0 in IDLE.
REQ-024 On en_i with last_o high: done_o pulses; if wrap=1 all counts reload start values and state stays RUN; if wrap=0 count_o holds the final point and state goes to HOLD.
REQ-025 In RUN with en_i low, count_o SHALL hold.
REQ-026 In HOLD, count_o SHALL hold the final point, busy_o=0, last_o=1, en_i ignored.
REQ-027 If end[d] < start[d] the dimension SHALL behave as a single value (start only); when assert_on_i, an error SHALL be reported at start_i.
REQ-028 Latency: count_o updates on the clock edge after the qualifying start_i/en_i.

Reset
REQ-029 While rst_ni=0: count_o=0, busy_o=0, last_o=0, done_o=0, latched config=0, state IDLE, independent of clk_i.
REQ-030 Reset asserted mid-run SHALL abort immediately; deassertion returns to IDLE with no done_o.

Structure
REQ-031 A shared package counter_pkg SHALL hold the state enum (IDLE/RUN/HOLD).
REQ-032 Per-dimension step/compare/reload logic SHALL be one sub-module, range_step_dim, instantiated Dims times via generate; carry chain and FSM in the top.

Verification
REQ-033 Bits=8, Dims=1, start=0, end=9, step=3, wrap=0, en held -> count 0,3,6,9; done_o pulse on the step after 9; HOLD at 9.
REQ-034 Dims=2, start={0,0}, end={2,1}, step={1,1}, wrap=1 -> (d1,d0) sequence (0,0),(0,1),(0,2),(1,0),(1,1),(1,2),(0,0); done_o once at the return to (0,0).
REQ-035 start=0xFA, end=0xFF, step=4, Dims=1 -> count 0xFA,0xFE, then final point; no wrap to 0x02.
REQ-036 Toggle en_i every cycle from (0,0) of REQ-034 config -> count advances only on en_i-high cycles.
REQ-037 rst_ni pulsed low for 2 ns between edges mid-run -> all outputs 0 immediately, IDLE after release.
REQ-038 start_i with new start=5 while RUN at count 7 and en_i high -> next count 5, no advance, no done_o.
